// File: rtl/axis_slice_pkg.sv
// Shared types and defaults for the AXI4-Stream register slice.
package axis_slice_pkg;

  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } slice_state_t;

endpackage

// File: rtl/axis_skid_ctrl.sv
// Occupancy FSM for the 2-entry skid buffer: registered ready/valid plus data load enables.
// state | meaning
// EMPTY | no beat held, master valid low
// ONE   | main register holds a beat
// FULL  | main and skid hold beats, slave ready low
module axis_skid_ctrl
  import axis_slice_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic s_valid,
  input  logic m_ready,
  output logic s_ready,
  output logic m_valid,
  output logic load_main,
  output logic load_skid,
  output logic skid_to_main
);

  slice_state_t state;
  slice_state_t state_next;
  logic         accept;
  logic         deliver;

  assign accept  = s_valid & s_ready;
  assign deliver = m_valid & m_ready;

  always_comb begin
    state_next   = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          state_next = ONE;
          load_main  = 1'b1;
        end
      end
      ONE: begin
        case ({accept, deliver})
          2'b10: begin
            state_next = FULL;
            load_skid  = 1'b1;
          end
          2'b01: state_next = EMPTY;
          2'b11: load_main = 1'b1;
          default: state_next = ONE;
        endcase
      end
      FULL: begin
        if (deliver) begin
          state_next   = ONE;
          skid_to_main = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Handshake outputs are registered from the next state so neither side sees a combinational path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
    end else begin
      state   <= state_next;
      s_ready <= (state_next != FULL);
      m_valid <= (state_next != EMPTY);
    end
  end

endmodule

// File: rtl/axis_reg_slice.sv
// Full AXI4-Stream register slice; define AXIS_SLICE_CNT_EN to add the delivered-beat counter beat_cnt.
module axis_reg_slice
  import axis_slice_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk_0,
  input  logic          reset_0,
  input  logic [DW-1:0] s_0_tdata,
  input  logic          s_0_tvalid,
  output logic          s_0_tready,
  output logic [DW-1:0] m_0_tdata,
  output logic          m_0_tvalid,
  input  logic          m_0_tready
`ifdef AXIS_SLICE_CNT_EN
  ,
  output logic [15:0]   beat_cnt
`endif
);

  logic          load_main;
  logic          load_skid;
  logic          skid_to_main;
  logic [DW-1:0] main_q;
  logic [DW-1:0] skid_q;

  axis_skid_ctrl u_ctrl (
    .clk          (clk_0),
    .rst          (reset_0),
    .s_valid      (s_0_tvalid),
    .m_ready      (m_0_tready),
    .s_ready      (s_0_tready),
    .m_valid      (m_0_tvalid),
    .load_main    (load_main),
    .load_skid    (load_skid),
    .skid_to_main (skid_to_main)
  );

  // Data is captured verbatim; no qualification of X/Z bits.
  always_ff @(posedge clk_0 or posedge reset_0) begin
    if (reset_0) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (skid_to_main)
        main_q <= skid_q;
      else if (load_main)
        main_q <= s_0_tdata;
      if (load_skid)
        skid_q <= s_0_tdata;
    end
  end

  assign m_0_tdata = main_q;

`ifdef AXIS_SLICE_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk_0 or posedge reset_0) begin
    if (reset_0)
      cnt_q <= '0;
    else if (m_0_tvalid && m_0_tready)
      cnt_q <= cnt_q + 16'd1;
  end

  assign beat_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_axis_reg_slice.sv
// Scoreboard bench for axis_reg_slice: directed scenarios plus random valid/ready traffic.
module tb_axis_reg_slice;

  logic       clk_0;
  logic       reset_0;
  logic [7:0] s_0_tdata;
  logic       s_0_tvalid;
  logic       s_0_tready;
  logic [7:0] m_0_tdata;
  logic       m_0_tvalid;
  logic       m_0_tready;
`ifdef AXIS_SLICE_CNT_EN
  logic [15:0] beat_cnt;
`endif

  int         n_chk;
  int         n_fail;
  logic [7:0] sb[$];
  logic       mon_en;
  int         exp_cnt;

  axis_reg_slice #(.DW(8)) dut (
    .clk_0      (clk_0),
    .reset_0    (reset_0),
    .s_0_tdata  (s_0_tdata),
    .s_0_tvalid (s_0_tvalid),
    .s_0_tready (s_0_tready),
    .m_0_tdata  (m_0_tdata),
    .m_0_tvalid (m_0_tvalid),
    .m_0_tready (m_0_tready)
`ifdef AXIS_SLICE_CNT_EN
    ,
    .beat_cnt   (beat_cnt)
`endif
  );

  initial begin
    clk_0 = 1'b0;
    forever #5 clk_0 = ~clk_0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  // Reference model: queue occupancy predicts ready/valid, queue order predicts data.
  always @(negedge clk_0) begin
    if (mon_en) begin
      chk("m_valid_model", 32'(m_0_tvalid), 32'(sb.size() != 0));
      chk("s_ready_model", 32'(s_0_tready), 32'(sb.size() < 2));
`ifdef AXIS_SLICE_CNT_EN
      chk("beat_cnt_model", 32'(beat_cnt), 32'(exp_cnt & 16'hFFFF));
`endif
      if (m_0_tvalid && m_0_tready) begin
        if (sb.size() == 0)
          chk("sb_underflow", 32'(m_0_tvalid), 32'd0);
        else
          chk("sb_data", 32'(m_0_tdata), 32'(sb.pop_front()));
        exp_cnt++;
      end
      if (s_0_tvalid && s_0_tready)
        sb.push_back(s_0_tdata);
    end
  end

  task automatic step();
    @(posedge clk_0);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk_0);
    #2 reset_0 = 1'b0;
    chk("rdy_before_edge", 32'(s_0_tready), 32'd0);
    step();
    chk("rdy_after_edge", 32'(s_0_tready), 32'd1);
    chk("valid_after_rel", 32'(m_0_tvalid), 32'd0);
    mon_en = 1'b1;
  endtask

  task automatic do_reset();
    mon_en     = 1'b0;
    reset_0    = 1'b1;
    s_0_tvalid = 1'b0;
    s_0_tdata  = 8'h00;
    m_0_tready = 1'b1;
    sb.delete();
    exp_cnt = 0;
    repeat (2) step();
    chk("rst_m_valid", 32'(m_0_tvalid), 32'd0);
    chk("rst_s_ready", 32'(s_0_tready), 32'd0);
    chk("rst_m_data", 32'(m_0_tdata), 32'd0);
`ifdef AXIS_SLICE_CNT_EN
    chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
`endif
    release_reset();
  endtask

  initial begin
    logic [7:0] stream[3];
    n_chk      = 0;
    n_fail     = 0;
    mon_en     = 1'b0;
    exp_cnt    = 0;
    reset_0    = 1'b1;
    s_0_tvalid = 1'b0;
    s_0_tdata  = 8'h00;
    m_0_tready = 1'b0;

    do_reset();

    // single beat
    m_0_tready = 1'b1;
    s_0_tvalid = 1'b1;
    s_0_tdata  = 8'h68;
    step();
    s_0_tvalid = 1'b0;
    s_0_tdata  = 8'hEE;
    chk("single_valid", 32'(m_0_tvalid), 32'd1);
    chk("single_data", 32'(m_0_tdata), 32'h68);
    step();
    chk("single_one_cycle", 32'(m_0_tvalid), 32'd0);

    // back-to-back streaming from a fresh reset
    do_reset();
    stream[0] = 8'h68;
    stream[1] = 8'h01;
    stream[2] = 8'hA5;
    m_0_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_0_tvalid = 1'b1;
      s_0_tdata  = stream[i];
      step();
      chk("stream_valid", 32'(m_0_tvalid), 32'd1);
      chk("stream_data", 32'(m_0_tdata), 32'(stream[i]));
      chk("stream_ready", 32'(s_0_tready), 32'd1);
    end
    s_0_tvalid = 1'b0;
    step();
    chk("stream_done", 32'(m_0_tvalid), 32'd0);
`ifdef AXIS_SLICE_CNT_EN
    chk("stream_beat_cnt", 32'(beat_cnt), 32'd3);
`endif

    // backpressure fills both entries
    m_0_tready = 1'b0;
    s_0_tvalid = 1'b1;
    s_0_tdata  = 8'h11;
    step();
    chk("bp_first_ready", 32'(s_0_tready), 32'd1);
    chk("bp_first_data", 32'(m_0_tdata), 32'h11);
    s_0_tdata = 8'h22;
    step();
    chk("bp_full_ready", 32'(s_0_tready), 32'd0);
    chk("bp_full_data", 32'(m_0_tdata), 32'h11);
    s_0_tdata = 8'h99;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("bp_hold_data", 32'(m_0_tdata), 32'h11);
      chk("bp_hold_valid", 32'(m_0_tvalid), 32'd1);
      chk("bp_hold_ready", 32'(s_0_tready), 32'd0);
    end
    s_0_tvalid = 1'b0;
    m_0_tready = 1'b1;
    step();
    chk("bp_second_data", 32'(m_0_tdata), 32'h22);
    chk("bp_second_valid", 32'(m_0_tvalid), 32'd1);
    chk("bp_ready_again", 32'(s_0_tready), 32'd1);
    step();
    chk("bp_drained", 32'(m_0_tvalid), 32'd0);

    // random traffic, scoreboarded by the monitor
    for (int i = 0; i < 200; i++) begin
      s_0_tvalid = 1'($urandom_range(0, 1));
      s_0_tdata  = 8'($urandom);
      m_0_tready = ($urandom_range(0, 3) != 0);
      step();
    end
    s_0_tvalid = 1'b0;
    m_0_tready = 1'b1;
    repeat (4) step();
    chk("drain_queue_empty", 32'(sb.size()), 32'd0);
    chk("drain_valid", 32'(m_0_tvalid), 32'd0);

    // reset asserted while FULL, away from any clock edge
    m_0_tready = 1'b0;
    s_0_tvalid = 1'b1;
    s_0_tdata  = 8'h33;
    step();
    s_0_tdata = 8'h44;
    step();
    s_0_tvalid = 1'b0;
    chk("pre_rst_full", 32'(s_0_tready), 32'd0);
    @(negedge clk_0);
    mon_en  = 1'b0;
    #2 reset_0 = 1'b1;
    #1;
    chk("async_rst_valid", 32'(m_0_tvalid), 32'd0);
    chk("async_rst_ready", 32'(s_0_tready), 32'd0);
    chk("async_rst_data", 32'(m_0_tdata), 32'd0);
`ifdef AXIS_SLICE_CNT_EN
    chk("async_rst_cnt", 32'(beat_cnt), 32'd0);
`endif
    sb.delete();
    exp_cnt    = 0;
    m_0_tready = 1'b1;
    step();
    release_reset();
    repeat (2) step();
    chk("post_rst_no_beats", 32'(m_0_tvalid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
